// File: rtl/bouncing_box_renderer.sv
// Draws a bouncing, colour-changing square over a flat background; position steps once per frame.
// color/h_sync_out/v_sync_out are 2 clocks behind row/column/display_active/syncs; no backpressure.
module bouncing_box_renderer #(
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter int         BOX_SIZE  = 32,
  parameter int         STEP      = 1,
  parameter logic [2:0] BG_COLOR  = 3'b001,
  parameter logic [2:0] BOX_COLOR = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] row,
  input  logic [9:0] column,
  input  logic       display_active,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       enable,
  output logic [2:0] color,
  output logic       h_sync_out,
  output logic       v_sync_out
);

  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] BS = 11'(BOX_SIZE);
  localparam logic [10:0] ST = 11'(STEP);

  logic [9:0]  box_x, box_x_nxt;
  logic [8:0]  box_y, box_y_nxt;
  logic        dir_x, dir_x_nxt;  // 0 = increasing, 1 = decreasing
  logic        dir_y, dir_y_nxt;
  logic [2:0]  box_col, box_col_nxt;
  logic        bounce_x, bounce_y;
  logic        v_sync_prev, vs_armed, tick;
  logic [10:0] nx, ny, x_end, y_end;
  logic        in_box;
  logic        act1, in1, hs1, vs1;

  // vs_armed blocks a false edge when v_sync_in is already low as reset releases.
  assign tick = v_sync_prev & vs_armed & ~v_sync_in & enable;

  always_comb begin
    nx          = {1'b0, box_x} + ST;
    ny          = {2'b0, box_y} + ST;
    box_x_nxt   = box_x;
    box_y_nxt   = box_y;
    dir_x_nxt   = dir_x;
    dir_y_nxt   = dir_y;
    bounce_x    = 1'b0;
    bounce_y    = 1'b0;
    box_col_nxt = box_col;

    if (!dir_x) begin
      if (nx + BS >= HA) begin
        box_x_nxt = 10'(HA - BS);
        dir_x_nxt = 1'b1;
        bounce_x  = 1'b1;
      end else begin
        box_x_nxt = 10'(nx);
      end
    end else if ({1'b0, box_x} <= ST) begin
      box_x_nxt = '0;
      dir_x_nxt = 1'b0;
      bounce_x  = 1'b1;
    end else begin
      box_x_nxt = box_x - 10'(STEP);
    end

    if (!dir_y) begin
      if (ny + BS >= VA) begin
        box_y_nxt = 9'(VA - BS);
        dir_y_nxt = 1'b1;
        bounce_y  = 1'b1;
      end else begin
        box_y_nxt = 9'(ny);
      end
    end else if ({2'b0, box_y} <= ST) begin
      box_y_nxt = '0;
      dir_y_nxt = 1'b0;
      bounce_y  = 1'b1;
    end else begin
      box_y_nxt = box_y - 9'(STEP);
    end

    // A corner hit still advances the colour only once; 0 is never used.
    if (bounce_x || bounce_y)
      box_col_nxt = (box_col == 3'd7) ? 3'd1 : box_col + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x       <= '0;
      box_y       <= '0;
      dir_x       <= 1'b0;
      dir_y       <= 1'b0;
      box_col     <= BOX_COLOR;
      v_sync_prev <= 1'b1;
      vs_armed    <= 1'b0;
    end else begin
      v_sync_prev <= v_sync_in;
      if (v_sync_in)
        vs_armed <= 1'b1;
      if (tick) begin
        box_x   <= box_x_nxt;
        box_y   <= box_y_nxt;
        dir_x   <= dir_x_nxt;
        dir_y   <= dir_y_nxt;
        box_col <= box_col_nxt;
      end
    end
  end

  always_comb begin
    x_end  = {1'b0, box_x} + BS;
    y_end  = {2'b0, box_y} + BS;
    in_box = ({1'b0, column} >= {1'b0, box_x}) && ({1'b0, column} < x_end) &&
             ({2'b0, row} >= {2'b0, box_y}) && ({2'b0, row} < y_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act1       <= 1'b0;
      in1        <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      color      <= 3'b000;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else begin
      act1       <= display_active;
      in1        <= in_box;
      hs1        <= h_sync_in;
      vs1        <= v_sync_in;
      color      <= !act1 ? 3'b000 : (in1 ? box_col : BG_COLOR);
      h_sync_out <= hs1;
      v_sync_out <= vs1;
    end
  end

endmodule

// File: doc/bouncing_box_renderer.md
Name: bouncing_box_renderer

Overview:
- Pixel-generation stage that sits directly downstream of the VGA timing controller.
- Consumes row, column, display-active and the raw syncs, and produces the registered 3-bit RGB color plus delayed syncs that go to the pins.
- Draws a solid square on a background colour. The square moves one step per frame and bounces off the screen edges, changing colour on every bounce.
- Delays the syncs by the pixel-pipeline latency so that color stays aligned with them.

Parameters:
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible rows.
- BOX_SIZE, 32, square side in pixels. Must be < V_ACTIVE.
- STEP, 1, pixels moved per frame on each axis. Must be >= 1.
- BG_COLOR, 3'b001, background colour in the active area.
- BOX_COLOR, 3'b110, square colour after reset.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- row  in  9  current row from timing controller, 0..V_ACTIVE-1 when active.
- column  in  10  current column, 0..H_ACTIVE-1 when active.
- display_active  in  1  high when row/column are inside the visible area.
- h_sync_in  in  1  raw hSync, active low.
- v_sync_in  in  1  raw vSync, active low.
- enable  in  1  high allows motion; low freezes position and colour.
- color  out  3  {R,G,B} pixel output, registered.
- h_sync_out  out  1  h_sync_in delayed 2 clocks.
- v_sync_out  out  1  v_sync_in delayed 2 clocks.

Behaviour:

Reset (asynchronous):
- color=0, h_sync_out=1, v_sync_out=1, all pipeline flops cleared (syncs to 1).
- box_x=0, box_y=0, dir_x=+, dir_y=+, box_col=BOX_COLOR, v_sync_prev=1.

Frame tick:
- One-cycle pulse when v_sync_prev=1 and v_sync_in=0 (falling edge). v_sync_prev is registered every clock.
- Position and colour update only on a tick with enable=1. The tick falls in vertical blanking, so nothing changes mid-frame.

X update, on tick (Y is identical with V_ACTIVE, box_y, dir_y):
- dir_x=+: n=box_x+STEP. If n+BOX_SIZE >= H_ACTIVE then box_x=H_ACTIVE-BOX_SIZE, dir_x=-, bounce_x=1. Otherwise box_x=n.
- dir_x=-: if box_x <= STEP then box_x=0, dir_x=+, bounce_x=1. Otherwise box_x=box_x-STEP.

Colour update:
- If bounce_x or bounce_y is set on the tick, box_col=box_col+1 mod 8, with 0 skipped (7 goes to 1).
- A simultaneous X and Y bounce (corner hit) increments box_col once only.

Arithmetic:
- Position registers are 10 bits (x) and 9 bits (y).
- Comparisons use 11-bit unsigned intermediates; no wrap is permitted.

Pixel pipeline, fixed latency of 2 clocks from row/column/display_active/syncs to color/syncs out:
- Stage 1 registers:
  - act1=display_active.
  - in1 = (column >= box_x) & (column < box_x+BOX_SIZE) & (row >= box_y) & (row < box_y+BOX_SIZE).
  - hs1, vs1.
- Stage 2 registers:
  - color = !act1 ? 0 : (in1 ? box_col : BG_COLOR).
  - h_sync_out=hs1, v_sync_out=vs1.

Other rules:
- Outside the active area, color is exactly 0 regardless of position.
- enable=0: ticks are ignored. The pipeline still runs and the box stays drawn at its current position.
- Reset mid-frame: all state returns to reset values immediately. The first frame after reset draws the box at (0,0).
- v_sync_in held low through reset deassertion gives no tick until it goes high and then low again.

Test Plan:
1. Assert rst for 3 clocks mid-line -> color=0, h_sync_out=1, v_sync_out=1 during reset; after release, a pixel at row=0,col=0 with display_active=1 gives color=3'b110 two clocks later.
2. Apply 1 tick (v_sync_in 1->0), enable=1 -> box_x=1, box_y=1. Then:
   - row=0,col=5 active -> color=3'b001 after 2 clocks.
   - row=1,col=1 -> 3'b110.
   - row=1,col=33 -> 3'b001.
3. Right wall: box_x=607, dir_x=+, box_y=100 -> after tick box_x=608, dir_x=-, box_col=3'b111. Next tick -> box_x=607, box_col unchanged.
4. Corner: box_x=607 dir+, box_y=447 dir+, box_col=3'b111 -> after tick x=608, y=448, both dirs -, box_col=3'b001 (single increment, 0 skipped).
5. enable=0 for 5 ticks -> box_x, box_y, box_col unchanged. display_active=0 at any row/column -> color=0. Syncs exactly 2-clock delayed copies throughout.
6. Left wall: box_x=1, dir_x=-, STEP=1 -> after tick box_x=0, dir_x=+, colour increments by one.
